// File: rtl/counter_multi_ch.sv
// Multi-channel up/down counter with per-channel step, limit (wrap or saturate),
// synchronous load and sticky event flags. Each channel is an independent IDLE/RUN/HOLD FSM.
module counter_multi_ch #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NCH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH-1:0]         enable,
    input  logic [NCH-1:0]         up_down,
    input  logic [3*NCH-1:0]       mode,
    input  logic [NCH-1:0]         wrap_en,
    input  logic [NCH-1:0]         load,
    input  logic [WIDTH*NCH-1:0]   din,
    input  logic [WIDTH*NCH-1:0]   sat_count,
    input  logic [NCH-1:0]         event_clr,
    output logic [WIDTH*NCH-1:0]   count,
    output logic [NCH-1:0]         timer_event,
    output logic [NCH-1:0]         event_flag,
    output logic                   any_event
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [NCH-1:0] flag_nxt;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [1:0]       state;
        logic [1:0]       state_nxt;
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] cnt_nxt;
        logic [WIDTH-1:0] din_i;
        logic [WIDTH-1:0] sat_i;
        logic [WIDTH:0]   step;
        logic [WIDTH:0]   sum;
        logic             ev_q;
        logic             ev_nxt;
        logic             flag_q;
        logic             hold_up;
        logic             hold_up_nxt;
        logic             parked;
        logic             parked_nxt;
        logic             at_lim;
        logic             stay_held;

        assign din_i  = din[WIDTH*i +: WIDTH];
        assign sat_i  = sat_count[WIDTH*i +: WIDTH];
        assign step   = (WIDTH+1)'(mode[3*i +: 3]) + (WIDTH+1)'(1);
        assign sum    = {1'b0, cnt} + step;
        assign at_lim = hold_up ? (cnt == sat_i) : (cnt == '0);

        // Held either actively, or idled out of HOLD and re-enabled still sitting at that limit
        assign stay_held = (up_down[i] == hold_up) &&
                           ((state == ST_HOLD) ||
                            ((state == ST_IDLE) && parked && at_lim && !wrap_en[i]));

        always_comb begin
            state_nxt   = state;
            cnt_nxt     = cnt;
            ev_nxt      = 1'b0;
            hold_up_nxt = hold_up;
            parked_nxt  = parked;
            if (load[i]) begin
                cnt_nxt    = (din_i < sat_i) ? din_i : sat_i;
                state_nxt  = enable[i] ? ST_RUN : ST_IDLE;
                parked_nxt = 1'b0;
            end else if (!enable[i]) begin
                state_nxt = ST_IDLE;
                if (state == ST_HOLD) begin
                    parked_nxt = 1'b1;
                end
            end else if (stay_held) begin
                state_nxt  = ST_HOLD;
                parked_nxt = 1'b0;
            end else begin
                state_nxt  = ST_RUN;
                parked_nxt = 1'b0;
                if (up_down[i]) begin
                    if (sum < {1'b0, sat_i}) begin
                        cnt_nxt = sum[WIDTH-1:0];
                    end else begin
                        ev_nxt = 1'b1;
                        if (wrap_en[i]) begin
                            cnt_nxt = '0;
                        end else begin
                            cnt_nxt     = sat_i;
                            state_nxt   = ST_HOLD;
                            hold_up_nxt = 1'b1;
                        end
                    end
                end else begin
                    if ({1'b0, cnt} > step) begin
                        cnt_nxt = cnt - step[WIDTH-1:0];
                    end else begin
                        ev_nxt = 1'b1;
                        if (wrap_en[i]) begin
                            cnt_nxt = sat_i;
                        end else begin
                            cnt_nxt     = '0;
                            state_nxt   = ST_HOLD;
                            hold_up_nxt = 1'b0;
                        end
                    end
                end
            end
        end

        // Set beats a same-cycle clear
        assign flag_nxt[i] = ev_nxt | (flag_q & ~event_clr[i]);

        always_ff @(posedge clk) begin
            if (!reset) begin
                state   <= ST_IDLE;
                cnt     <= '0;
                ev_q    <= 1'b0;
                flag_q  <= 1'b0;
                hold_up <= 1'b0;
                parked  <= 1'b0;
            end else begin
                state   <= state_nxt;
                cnt     <= cnt_nxt;
                ev_q    <= ev_nxt;
                flag_q  <= flag_nxt[i];
                hold_up <= hold_up_nxt;
                parked  <= parked_nxt;
            end
        end

        assign count[WIDTH*i +: WIDTH] = cnt;
        assign timer_event[i]          = ev_q;
        assign event_flag[i]           = flag_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            any_event <= 1'b0;
        end else begin
            any_event <= |flag_nxt;
        end
    end

endmodule

// File: tb/tb_counter_multi_ch.sv
// Scoreboard bench for counter_multi_ch: directed vectors push expected values, a monitor pops and compares.
module tb_counter_multi_ch;

    localparam int W = 32;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     enable, up_down, wrap_en, load, event_clr;
    logic [3*N-1:0]   mode;
    logic [W*N-1:0]   din, sat_count, count;
    logic [N-1:0]     timer_event, event_flag;
    logic             any_event;

    always #5 clk = ~clk;

    counter_multi_ch #(.WIDTH(W), .NCH(N)) dut (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .mode(mode),
        .wrap_en(wrap_en), .load(load), .din(din), .sat_count(sat_count),
        .event_clr(event_clr), .count(count), .timer_event(timer_event),
        .event_flag(event_flag), .any_event(any_event)
    );

    typedef struct {
        string           name;
        logic [3:0]      mask;
        logic [3:0][31:0] cnt;
        logic [3:0]      ev;
        logic [3:0]      fl;
        logic            an;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    int   errors = 0;
    int   checks = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drv(input int c, input logic en, input logic ud, input logic [2:0] md,
                       input logic wr, input logic ld, input logic [31:0] d, input logic [31:0] s,
                       input logic clr);
        enable[c]         = en;
        up_down[c]        = ud;
        mode[3*c +: 3]    = md;
        wrap_en[c]        = wr;
        load[c]           = ld;
        din[W*c +: W]     = d;
        sat_count[W*c +: W] = s;
        event_clr[c]      = clr;
    endtask

    task automatic tick(input string name, input logic [3:0] mask,
                        input logic [31:0] c0, input logic [31:0] c1,
                        input logic [31:0] c2, input logic [31:0] c3,
                        input logic [3:0] ev, input logic [3:0] fl, input logic an);
        exp_t e;
        e.name = name; e.mask = mask;
        e.cnt[0] = c0; e.cnt[1] = c1; e.cnt[2] = c2; e.cnt[3] = c3;
        e.ev = ev; e.fl = fl; e.an = an;
        @(posedge clk);
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: outputs are registered, so compare shortly after each edge that has an expectation
    always @(posedge clk) begin
        #2;
        if (sb.size() > 0) begin
            m = sb.pop_front();
            for (int c = 0; c < N; c++) begin
                if (m.mask[c]) begin
                    cmp($sformatf("%s ch%0d count", m.name, c), count[W*c +: W], m.cnt[c]);
                    cmp($sformatf("%s ch%0d timer_event", m.name, c), 32'(timer_event[c]), 32'(m.ev[c]));
                    cmp($sformatf("%s ch%0d event_flag", m.name, c), 32'(event_flag[c]), 32'(m.fl[c]));
                end
            end
            cmp($sformatf("%s any_event", m.name), 32'(any_event), 32'(m.an));
        end
    end

    initial begin
        int up_exp[8]   = '{1, 3, 6, 10, 15, 21, 28, 36};
        int down_exp[7] = '{35, 33, 30, 26, 21, 15, 8};
        reset = 1'b0;
        enable = '0; up_down = '0; wrap_en = '0; load = '0; event_clr = '0;
        mode = '0; din = '0; sat_count = '0;
        tick("reset", 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 1'b0);
        reset = 1'b1;

        // Up-count with increasing steps into saturation
        for (int k = 0; k < 8; k++) begin
            drv(0, 1, 1, 3'(k), 0, 0, 0, 44, 0);
            tick($sformatf("up_m%0d", k), 4'h1, 32'(up_exp[k]), 0, 0, 0, 4'h0, 4'h0, 1'b0);
        end
        drv(0, 1, 1, 3'd7, 0, 0, 0, 44, 0);
        tick("up_sat", 4'h1, 44, 0, 0, 0, 4'h1, 4'h1, 1'b1);
        drv(0, 1, 1, 3'd0, 0, 0, 0, 44, 0);
        tick("up_hold", 4'h1, 44, 0, 0, 0, 4'h0, 4'h1, 1'b1);

        // Load then down-count into zero
        drv(0, 1, 0, 3'd0, 0, 1, 36, 44, 0);
        tick("load36", 4'h1, 36, 0, 0, 0, 4'h0, 4'h1, 1'b1);
        for (int k = 0; k < 7; k++) begin
            drv(0, 1, 0, 3'(k), 0, 0, 0, 44, 0);
            tick($sformatf("down_m%0d", k), 4'h1, 32'(down_exp[k]), 0, 0, 0, 4'h0, 4'h1, 1'b1);
        end
        drv(0, 1, 0, 3'd7, 0, 0, 0, 44, 0);
        tick("down_zero", 4'h1, 0, 0, 0, 0, 4'h1, 4'h1, 1'b1);
        drv(0, 1, 0, 3'd0, 0, 0, 0, 44, 0);
        tick("down_hold", 4'h1, 0, 0, 0, 0, 4'h0, 4'h1, 1'b1);
        drv(0, 1, 1, 3'd0, 0, 0, 0, 44, 0);
        tick("reverse", 4'h1, 1, 0, 0, 0, 4'h0, 4'h1, 1'b1);

        // Flag clear, load clamp, same-cycle set/clear, re-enable at the limit
        drv(0, 0, 1, 3'd0, 0, 0, 0, 44, 1);
        tick("clr", 4'h1, 1, 0, 0, 0, 4'h0, 4'h0, 1'b0);
        drv(0, 1, 1, 3'd0, 0, 1, 50, 44, 0);
        tick("clamp", 4'h1, 44, 0, 0, 0, 4'h0, 4'h0, 1'b0);
        drv(0, 1, 1, 3'd0, 0, 0, 0, 44, 1);
        tick("set_wins", 4'h1, 44, 0, 0, 0, 4'h1, 4'h1, 1'b1);
        drv(0, 0, 1, 3'd0, 0, 0, 0, 44, 1);
        tick("clr_after", 4'h1, 44, 0, 0, 0, 4'h0, 4'h0, 1'b0);
        drv(0, 1, 1, 3'd0, 0, 0, 0, 44, 0);
        tick("reen_hold", 4'h1, 44, 0, 0, 0, 4'h0, 4'h0, 1'b0);

        // Wrap at sat_count=10, step 4
        drv(0, 1, 1, 3'd3, 1, 1, 0, 10, 0);
        tick("wrap_load", 4'h1, 0, 0, 0, 0, 4'h0, 4'h0, 1'b0);
        drv(0, 1, 1, 3'd3, 1, 0, 0, 10, 0);
        tick("wrap_4", 4'h1, 4, 0, 0, 0, 4'h0, 4'h0, 1'b0);
        tick("wrap_8", 4'h1, 8, 0, 0, 0, 4'h0, 4'h0, 1'b0);
        tick("wrap_0", 4'h1, 0, 0, 0, 0, 4'h1, 4'h1, 1'b1);
        tick("wrap_4b", 4'h1, 4, 0, 0, 0, 4'h0, 4'h1, 1'b1);

        // Independence: ch1 up step 3, ch2 down step 5 from 50, ch3 disabled
        drv(0, 0, 1, 3'd3, 1, 0, 0, 10, 0);
        drv(1, 1, 1, 3'd2, 0, 0, 0, 100, 0);
        drv(2, 1, 0, 3'd4, 0, 1, 50, 100, 0);
        drv(3, 0, 1, 3'd7, 0, 0, 77, 100, 0);
        tick("indep_a", 4'hE, 0, 3, 50, 0, 4'h0, 4'h1, 1'b1);
        drv(2, 1, 0, 3'd4, 0, 0, 50, 100, 0);
        tick("indep_b", 4'hE, 0, 6, 45, 0, 4'h0, 4'h1, 1'b1);
        tick("indep_c", 4'hE, 0, 9, 40, 0, 4'h0, 4'h1, 1'b1);

        // Reset overrides load and enable
        reset = 1'b0;
        for (int c = 0; c < N; c++) drv(c, 1, 1, 3'd0, 0, 1, 5, 100, 0);
        tick("reset_mid", 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 1'b0);
        reset = 1'b1;

        // sat_count=0: event on the first counting cycle, then held
        for (int c = 0; c < 3; c++) drv(c, 0, 1, 3'd0, 0, 0, 0, 100, 0);
        drv(3, 1, 1, 3'd0, 0, 0, 0, 0, 0);
        tick("sat0", 4'hF, 0, 0, 0, 0, 4'h8, 4'h8, 1'b1);
        tick("sat0_hold", 4'hF, 0, 0, 0, 0, 4'h0, 4'h8, 1'b1);

        for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_multi_ch.md
COUNTER_MULTI_CH -- requirements
Module: counter_multi_ch

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the counter width in bits per channel.
REQ-002 The block SHALL have parameter NCH, default 4, meaning the number of independent channels.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, meaning reset, synchronous and active-low.
REQ-005 The block SHALL have port enable, input, NCH bits, meaning the per-channel count enable.
REQ-006 The block SHALL have port up_down, input, NCH bits, meaning per-channel direction: 1 counts up, 0 counts down.
REQ-007 The block SHALL have port mode, input, 3*NCH bits, meaning the per-channel step select; channel i step = mode[3i+2:3i] + 1 (range 1..8).
REQ-008 The block SHALL have port wrap_en, input, NCH bits, meaning per-channel limit behaviour: 1 wraps at the limit, 0 saturates.
REQ-009 The block SHALL have port load, input, NCH bits, meaning a per-channel synchronous load of din.
REQ-010 The block SHALL have port din, input, WIDTH*NCH bits, meaning the per-channel load value; channel i uses slice [WIDTH*i +: WIDTH].
REQ-011 The block SHALL have port sat_count, input, WIDTH*NCH bits, meaning the per-channel upper limit, sliced like din.
REQ-012 The block SHALL have port event_clr, input, NCH bits, meaning a per-channel clear of event_flag.
REQ-013 The block SHALL have port count, output, WIDTH*NCH bits, meaning the registered per-channel count.
REQ-014 The block SHALL have port timer_event, output, NCH bits, meaning a registered 1-cycle pulse when a channel hits or wraps a limit.
REQ-015 The block SHALL have port event_flag, output, NCH bits, meaning a sticky per-channel event indication.
REQ-016 The block SHALL have port any_event, output, 1 bit, meaning the OR of all event_flag bits.

Function
REQ-017 Each channel SHALL be fully independent; no input of channel i affects any output of channel j.
REQ-018 Each channel SHALL run an FSM with states IDLE (enable=0), RUN (counting) and HOLD (saturated at a limit, wrap_en=0).
REQ-019 Per channel and cycle, priority SHALL be: reset > load > enable counting > hold value.
REQ-020 load=1 SHALL set count=min(din, sat_count) on the next edge, enter RUN if enable=1 (else IDLE), and produce no timer_event.
REQ-021 Up-count SHALL compute count+step in WIDTH+1 bits; if the result < sat_count, count takes the result.
REQ-022 Up-count with result >= sat_count and wrap_en=0 SHALL set count=sat_count, pulse timer_event, and enter HOLD.
REQ-023 Up-count with result >= sat_count and wrap_en=1 SHALL set count=0, pulse timer_event, and stay in RUN.
REQ-024 Down-count with count > step SHALL set count=count-step.
REQ-025 Down-count with count <= step and wrap_en=0 SHALL set count=0, pulse timer_event, and enter HOLD.
REQ-026 Down-count with count <= step and wrap_en=1 SHALL set count=sat_count, pulse timer_event, and stay in RUN.
REQ-027 In HOLD, further counting toward the held limit SHALL leave count unchanged and SHALL NOT pulse timer_event.
REQ-028 In HOLD, a direction reversal or load SHALL return the channel to RUN and count normally that cycle.
REQ-029 enable=0 SHALL freeze count and enter IDLE; re-enable SHALL return to RUN, or to HOLD if count still sits at the limit for the current direction.
REQ-030 event_flag[i] SHALL set on timer_event[i] and clear on event_clr[i]; if both occur in the same cycle, set wins.
REQ-031 timer_event and count SHALL update on the same clock edge with 1-cycle latency from the inputs.
REQ-032 Behaviour with sat_count=0 SHALL be: count held at 0, and timer_event pulses on the first counting cycle after entering RUN.

Reset
REQ-033 On a clk edge with reset=0, every channel SHALL take count=0, FSM=IDLE, timer_event=0 and event_flag=0; any_event=0.
REQ-034 Reset asserted mid-operation SHALL override load, enable and event_clr in that cycle.

Verification
REQ-035 The bench SHALL cover up-count: channel 0, sat_count=44, up, modes 0..7 one cycle each, then mode 7 again -> count 1,3,6,10,15,21,28,36,44; timer_event only on the 44 cycle; then HOLD.
REQ-036 The bench SHALL cover down-count: load din=36, then down with modes 0..7 -> count 35,33,30,26,21,15,8,0; timer_event on the 0 cycle.
REQ-037 The bench SHALL cover wrap: sat_count=10, wrap_en=1, mode=3, up from 0 -> count 4,8,0,4; timer_event on the 0 cycle; event_flag stays 1.
REQ-038 The bench SHALL cover load clamp and same-cycle set/clear: load din=50 with sat_count=44 -> count 44; event_clr asserted on an event cycle -> event_flag remains 1; the following event_clr -> event_flag 0.
REQ-039 The bench SHALL cover independence: channel 1 counts up while channel 2 counts down with different modes -> per-channel values match their own models, and channel 3 (enable=0) stays at 0.
REQ-040 The bench SHALL cover reset mid-operation: reset=0 while load=1 and enable=1 -> all counts 0, event_flag 0, any_event 0 on the next edge.
